// File: rtl/asg_sweep_pkg.sv
// -----------------------------------------------------------------------------
// asg_sweep_pkg
// Shared definitions for the ASG frequency-sweep sequencer:
//   - sweep_state_e : sequencer states (IDLE / RUN / DONE)
//   - sw_width()    : step word width from the channel buffer address width
//                     (integer step bits plus 32 fraction bits)
//   - DWELL_MIN     : value substituted for a programmed dwell of 0
// -----------------------------------------------------------------------------
package asg_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sweep_state_e;

   // A dwell of 0 would never produce a tick, so it is run as a dwell of 1.
   localparam logic [31:0] DWELL_MIN = 32'd1;

   function automatic int sw_width(input int rsz);
      return rsz + 48;
   endfunction

endpackage

// File: rtl/asg_sweep_step.sv
// -----------------------------------------------------------------------------
// asg_sweep_step
// Combinational clamped add/subtract for the sweep step word.
//   cur     : current step word
//   inc     : unsigned increment
//   stop    : sweep end value; results past it (or wrapping) clamp to it
//   dir_up  : 1 = add, 0 = subtract
//   nxt     : next step word
//   at_stop : current step word equals stop
// -----------------------------------------------------------------------------
module asg_sweep_step
   import asg_sweep_pkg::*;
#(
   parameter int SW = sw_width(14)
) (
   input  logic [SW-1:0] cur,
   input  logic [SW-1:0] inc,
   input  logic [SW-1:0] stop,
   input  logic          dir_up,
   output logic [SW-1:0] nxt,
   output logic          at_stop
);

   // One extra bit catches carry out of the add and borrow out of the subtract.
   logic [SW:0] sum_s;
   logic [SW:0] diff_s;

   assign sum_s   = {1'b0, cur} + {1'b0, inc};
   assign diff_s  = {1'b0, cur} - {1'b0, inc};
   assign at_stop = (cur == stop);

   // Select the moved value, clamping to stop on overshoot or wrap.
   always_comb begin
      nxt = cur;
      if (dir_up) begin
         if (sum_s[SW] || (sum_s[SW-1:0] > stop)) begin
            nxt = stop;
         end else begin
            nxt = sum_s[SW-1:0];
         end
      end else begin
         if (diff_s[SW] || (diff_s[SW-1:0] < stop)) begin
            nxt = stop;
         end else begin
            nxt = diff_s[SW-1:0];
         end
      end
   end

endmodule

// File: rtl/asg_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// asg_sweep_ctrl
// Frequency-sweep sequencer for one ASG channel. Steps the channel phase-step
// word linearly from start to stop, holding each value for a dwell time, once
// or repeatedly.
// Ports:
//   dac_clk_i, dac_rst_i        : clock, synchronous active-high reset
//   start_i / abort_i           : single-cycle start(retrigger) / abort
//   cfg_start_i/stop_i/inc_i    : sweep start, stop and increment (SW bits)
//   cfg_dwell_i                 : cycles per step value (0 runs as 1)
//   cfg_repeat_i                : 1 = repeat indefinitely
//   cfg_pp_i                    : ping-pong select (ASG_SWEEP_PINGPONG_EN only)
//   step_o                      : registered step word to the channel
//   upd_o, busy_o, wrap_o, done_o : update pulse, RUN flag, wrap / done pulses
// Build option: define ASG_SWEEP_PINGPONG_EN to add ping-pong repeat.
// -----------------------------------------------------------------------------
module asg_sweep_ctrl
   import asg_sweep_pkg::*;
#(
   parameter int RSZ = 14,
   parameter int SW  = sw_width(RSZ)
) (
   input  logic          dac_clk_i,
   input  logic          dac_rst_i,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic [SW-1:0] cfg_start_i,
   input  logic [SW-1:0] cfg_stop_i,
   input  logic [SW-1:0] cfg_inc_i,
   input  logic [31:0]   cfg_dwell_i,
   input  logic          cfg_repeat_i,
`ifdef ASG_SWEEP_PINGPONG_EN
   input  logic          cfg_pp_i,
`endif
   output logic [SW-1:0] step_o,
   output logic          upd_o,
   output logic          busy_o,
   output logic          wrap_o,
   output logic          done_o
);

   sweep_state_e state_r, nxt_state_s;

   logic [SW-1:0] start_r, stop_r, inc_r, step_r;
   logic [SW-1:0] start_s, stop_s, inc_s, step_s;
   logic [31:0]   dwell_r, cnt_r, dwell_s, cnt_s, dwell_n_s;
   logic          repeat_r, dir_up_r, upd_r, busy_r, wrap_r, done_r;
   logic          repeat_s, dir_up_s, upd_s, busy_s, wrap_s, done_s;
`ifdef ASG_SWEEP_PINGPONG_EN
   logic          pp_r, pp_s;
`endif
   logic [SW-1:0] step_nxt_s;
   logic          at_stop_s;
   logic          tick_s;

   assign dwell_n_s = (cfg_dwell_i == 32'd0) ? DWELL_MIN : cfg_dwell_i;
   assign tick_s    = (state_r == ST_RUN) && (cnt_r == 32'd0);

   asg_sweep_step #(.SW(SW)) u_step (
      .cur     (step_r),
      .inc     (inc_r),
      .stop    (stop_r),
      .dir_up  (dir_up_r),
      .nxt     (step_nxt_s),
      .at_stop (at_stop_s)
   );

   // State register.
   always_ff @(posedge dac_clk_i) begin
      if (dac_rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= nxt_state_s;
      end
   end

   // Next-state logic: abort beats start, start beats the dwell tick.
   always_comb begin
      nxt_state_s = state_r;
      if (abort_i) begin
         nxt_state_s = ST_IDLE;
      end else if (start_i) begin
         nxt_state_s = ST_RUN;
      end else begin
         case (state_r)
            ST_IDLE: nxt_state_s = ST_IDLE;
            ST_DONE: nxt_state_s = ST_DONE;
            ST_RUN: begin
               if (tick_s && at_stop_s && !repeat_r) begin
                  nxt_state_s = ST_DONE;
               end else begin
                  nxt_state_s = ST_RUN;
               end
            end
            default: nxt_state_s = ST_IDLE;
         endcase
      end
   end

   // Output / datapath logic: next values for config latches, counter and outputs.
   always_comb begin
      start_s  = start_r;
      stop_s   = stop_r;
      inc_s    = inc_r;
      dwell_s  = dwell_r;
      repeat_s = repeat_r;
`ifdef ASG_SWEEP_PINGPONG_EN
      pp_s     = pp_r;
`endif
      dir_up_s = dir_up_r;
      cnt_s    = cnt_r;
      step_s   = step_r;
      upd_s    = 1'b0;
      wrap_s   = 1'b0;
      done_s   = 1'b0;
      busy_s   = (nxt_state_s == ST_RUN);
      if (abort_i) begin
         step_s = start_r;
         upd_s  = (step_r != start_r);
      end else if (start_i) begin
         start_s  = cfg_start_i;
         stop_s   = cfg_stop_i;
         inc_s    = cfg_inc_i;
         dwell_s  = dwell_n_s;
         repeat_s = cfg_repeat_i;
`ifdef ASG_SWEEP_PINGPONG_EN
         pp_s     = cfg_pp_i;
`endif
         dir_up_s = (cfg_stop_i >= cfg_start_i);
         cnt_s    = dwell_n_s - 32'd1;
         step_s   = cfg_start_i;
         upd_s    = 1'b1;
      end else if (tick_s) begin
         if (!at_stop_s) begin
            step_s = step_nxt_s;
            upd_s  = 1'b1;
            cnt_s  = dwell_r - 32'd1;
         end else if (repeat_r) begin
            cnt_s  = dwell_r - 32'd1;
            wrap_s = 1'b1;
`ifdef ASG_SWEEP_PINGPONG_EN
            if (pp_r) begin
               // Turn around: the stop value stays on the output for another dwell.
               start_s  = stop_r;
               stop_s   = start_r;
               dir_up_s = ~dir_up_r;
            end else begin
               step_s = start_r;
               upd_s  = 1'b1;
            end
`else
            step_s = start_r;
            upd_s  = 1'b1;
`endif
         end else begin
            done_s = 1'b1;
         end
      end else if (state_r == ST_RUN) begin
         cnt_s = cnt_r - 32'd1;
      end else begin
         cnt_s = cnt_r;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge dac_clk_i) begin
      if (dac_rst_i) begin
         start_r  <= {SW{1'b0}};
         stop_r   <= {SW{1'b0}};
         inc_r    <= {SW{1'b0}};
         dwell_r  <= 32'd0;
         repeat_r <= 1'b0;
`ifdef ASG_SWEEP_PINGPONG_EN
         pp_r     <= 1'b0;
`endif
         dir_up_r <= 1'b0;
         cnt_r    <= 32'd0;
         step_r   <= {SW{1'b0}};
         upd_r    <= 1'b0;
         busy_r   <= 1'b0;
         wrap_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         start_r  <= start_s;
         stop_r   <= stop_s;
         inc_r    <= inc_s;
         dwell_r  <= dwell_s;
         repeat_r <= repeat_s;
`ifdef ASG_SWEEP_PINGPONG_EN
         pp_r     <= pp_s;
`endif
         dir_up_r <= dir_up_s;
         cnt_r    <= cnt_s;
         step_r   <= step_s;
         upd_r    <= upd_s;
         busy_r   <= busy_s;
         wrap_r   <= wrap_s;
         done_r   <= done_s;
      end
   end

   assign step_o = step_r;
   assign upd_o  = upd_r;
   assign busy_o = busy_r;
   assign wrap_o = wrap_r;
   assign done_o = done_r;

endmodule

// File: tb/tb_asg_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_asg_sweep_ctrl
// Self-checking bench for asg_sweep_ctrl. Expected per-cycle outputs are pushed
// to a queue when a stimulus is applied and popped/compared one per clock.
// -----------------------------------------------------------------------------
module tb_asg_sweep_ctrl;
   import asg_sweep_pkg::*;

   localparam int SW = sw_width(14);

   logic          dac_clk_i = 1'b0;
   logic          dac_rst_i;
   logic          start_i, abort_i;
   logic [SW-1:0] cfg_start_i, cfg_stop_i, cfg_inc_i;
   logic [31:0]   cfg_dwell_i;
   logic          cfg_repeat_i;
`ifdef ASG_SWEEP_PINGPONG_EN
   logic          cfg_pp_i;
`endif
   logic [SW-1:0] step_o;
   logic          upd_o, busy_o, wrap_o, done_o;

   always #5 dac_clk_i = ~dac_clk_i;

   asg_sweep_ctrl #(.RSZ(14)) dut (
      .dac_clk_i    (dac_clk_i),
      .dac_rst_i    (dac_rst_i),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .cfg_start_i  (cfg_start_i),
      .cfg_stop_i   (cfg_stop_i),
      .cfg_inc_i    (cfg_inc_i),
      .cfg_dwell_i  (cfg_dwell_i),
      .cfg_repeat_i (cfg_repeat_i),
`ifdef ASG_SWEEP_PINGPONG_EN
      .cfg_pp_i     (cfg_pp_i),
`endif
      .step_o       (step_o),
      .upd_o        (upd_o),
      .busy_o       (busy_o),
      .wrap_o       (wrap_o),
      .done_o       (done_o)
   );

   typedef struct {
      logic [SW-1:0] step;
      logic          upd, busy, wrap, done;
   } exp_t;

   typedef struct {
      int s, p, inc, dwell;
      bit rep;
      int n;
      int vals[8];
      bit wr[8];
   } vec_t;

   exp_t sb_q[$];
   int   tests_run = 0;
   int   tests_failed = 0;

   task automatic push(input int step, input bit upd, input bit busy,
                       input bit wrap, input bit done);
      exp_t e;
      e.step = SW'(step);
      e.upd  = upd;
      e.busy = busy;
      e.wrap = wrap;
      e.done = done;
      sb_q.push_back(e);
   endtask

   // One step value held for d cycles; upd/wrap only on its first cycle.
   task automatic push_run(input int val, input int d, input bit upd, input bit wrap);
      for (int c = 0; c < d; c++) begin
         push(val, (c == 0) && upd, 1'b1, (c == 0) && wrap, 1'b0);
      end
   endtask

   task automatic go(input int s, input int p, input int inc, input int dwell,
                     input bit rep, input bit pp);
      cfg_start_i  = SW'(s);
      cfg_stop_i   = SW'(p);
      cfg_inc_i    = SW'(inc);
      cfg_dwell_i  = 32'(dwell);
      cfg_repeat_i = rep;
`ifdef ASG_SWEEP_PINGPONG_EN
      cfg_pp_i     = pp;
`else
      if (pp) begin
         cfg_repeat_i = rep;
      end
`endif
      start_i = 1'b1;
   endtask

   // Advance one clock per queued entry and compare; config is scrambled after
   // the start edge to show that only latched values matter.
   task automatic drain(input string name);
      exp_t e;
      int   k;
      k = 0;
      while (sb_q.size() > 0) begin
         @(posedge dac_clk_i);
         #1;
         start_i      = 1'b0;
         abort_i      = 1'b0;
         cfg_start_i  = SW'($urandom);
         cfg_stop_i   = SW'($urandom);
         cfg_inc_i    = SW'($urandom_range(1, 9));
         cfg_dwell_i  = 32'($urandom_range(0, 5));
         cfg_repeat_i = 1'($urandom_range(0, 1));
         e = sb_q.pop_front();
         tests_run++;
         if (step_o !== e.step || upd_o !== e.upd || busy_o !== e.busy ||
             wrap_o !== e.wrap || done_o !== e.done) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got step=%0d upd=%0b busy=%0b wrap=%0b done=%0b, want step=%0d upd=%0b busy=%0b wrap=%0b done=%0b",
                     name, k, step_o, upd_o, busy_o, wrap_o, done_o,
                     e.step, e.upd, e.busy, e.wrap, e.done);
         end
         k++;
      end
   endtask

   vec_t tbl[3];

   initial begin
      int d;
      int last;

      dac_rst_i    = 1'b1;
      start_i      = 1'b0;
      abort_i      = 1'b0;
      cfg_start_i  = {SW{1'b0}};
      cfg_stop_i   = {SW{1'b0}};
      cfg_inc_i    = {SW{1'b0}};
      cfg_dwell_i  = 32'd0;
      cfg_repeat_i = 1'b0;
`ifdef ASG_SWEEP_PINGPONG_EN
      cfg_pp_i     = 1'b0;
`endif

      // Reset state.
      push(0, 0, 0, 0, 0);
      push(0, 0, 0, 0, 0);
      drain("reset");
      dac_rst_i = 1'b0;

      // Sweep vectors: start, stop, inc, dwell, repeat, expected value list.
      tbl[0] = '{s: 100, p: 130, inc: 10, dwell: 3, rep: 1'b0, n: 4,
                 vals: '{100, 110, 120, 130, 0, 0, 0, 0}, wr: '{0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[1] = '{s: 0, p: 25, inc: 10, dwell: 1, rep: 1'b0, n: 4,
                 vals: '{0, 10, 20, 25, 0, 0, 0, 0}, wr: '{0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[2] = '{s: 50, p: 20, inc: 15, dwell: 2, rep: 1'b1, n: 7,
                 vals: '{50, 35, 20, 50, 35, 20, 50, 0}, wr: '{0, 0, 0, 1, 0, 0, 1, 0}};

      for (int t = 0; t < 3; t++) begin
         go(tbl[t].s, tbl[t].p, tbl[t].inc, tbl[t].dwell, tbl[t].rep, 1'b0);
         d = (tbl[t].dwell == 0) ? 1 : tbl[t].dwell;
         for (int i = 0; i < tbl[t].n; i++) begin
            push_run(tbl[t].vals[i], d, 1'b1, tbl[t].wr[i]);
         end
         last = tbl[t].vals[tbl[t].n - 1];
         if (!tbl[t].rep) begin
            push(last, 0, 0, 0, 1);
            push(last, 0, 0, 0, 0);
            drain($sformatf("vec%0d", t));
         end else begin
            drain($sformatf("vec%0d", t));
            abort_i = 1'b1;
            push(tbl[t].s, last != tbl[t].s, 0, 0, 0);
            push(tbl[t].s, 0, 0, 0, 0);
            drain($sformatf("vec%0d_abort", t));
         end
      end

      // Abort mid-sweep at 120, then abort together with start.
      go(100, 130, 10, 3, 1'b0, 1'b0);
      push_run(100, 3, 1'b1, 1'b0);
      push_run(110, 3, 1'b1, 1'b0);
      push(120, 1, 1, 0, 0);
      drain("abort_run");
      abort_i = 1'b1;
      push(100, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) push(100, 0, 0, 0, 0);
      drain("abort_idle");
      go(7, 70, 7, 1, 1'b0, 1'b0);
      abort_i = 1'b1;
      push(100, 0, 0, 0, 0);
      push(100, 0, 0, 0, 0);
      drain("abort_vs_start");

      // Retrigger during RUN with new config, dwell 0 advancing every cycle.
      go(100, 130, 10, 3, 1'b0, 1'b0);
      push_run(100, 3, 1'b1, 1'b0);
      push(110, 1, 1, 0, 0);
      drain("retrig_pre");
      go(5, 9, 2, 0, 1'b0, 1'b0);
      push_run(5, 1, 1'b1, 1'b0);
      push_run(7, 1, 1'b1, 1'b0);
      push_run(9, 1, 1'b1, 1'b0);
      push(9, 0, 0, 0, 1);
      push(9, 0, 0, 0, 0);
      drain("retrig_dwell0");

      // Reset mid-sweep clears everything, including the latched start.
      go(40, 1000, 1, 1, 1'b1, 1'b0);
      push_run(40, 1, 1'b1, 1'b0);
      push_run(41, 1, 1'b1, 1'b0);
      drain("rst_pre");
      dac_rst_i = 1'b1;
      push(0, 0, 0, 0, 0);
      drain("rst_mid");
      dac_rst_i = 1'b0;
      abort_i = 1'b1;
      push(0, 0, 0, 0, 0);
      drain("rst_abort");

`ifdef ASG_SWEEP_PINGPONG_EN
      // Ping-pong: endpoints repeat once with wrap and no update.
      go(0, 20, 10, 1, 1'b1, 1'b1);
      push_run(0, 1, 1'b1, 1'b0);
      push_run(10, 1, 1'b1, 1'b0);
      push_run(20, 1, 1'b1, 1'b0);
      push_run(20, 1, 1'b0, 1'b1);
      push_run(10, 1, 1'b1, 1'b0);
      push_run(0, 1, 1'b1, 1'b0);
      push_run(0, 1, 1'b0, 1'b1);
      push_run(10, 1, 1'b1, 1'b0);
      drain("pingpong");
      abort_i = 1'b1;
      push(0, 1, 0, 0, 0);
      drain("pingpong_abort");
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/asg_sweep_ctrl.md
# asg_sweep_ctrl

Frequency-sweep sequencer for one arbitrary signal generator channel. It drives the channel's phase-step word, moving it linearly from a start value to a stop value in fixed increments. Each increment is held for a programmable dwell time, and the sweep can run once or repeat. It sits between the register bank and the channel's step inputs; the upper bits of `step_o` feed the channel's coarse step input and the low 32 bits feed its fine step input.

## Interface
Parameters:
- `RSZ`, 14: buffer address width of the driven channel.
- `SW`, RSZ+48: step word width, integer step bits plus 32 fraction bits.

Ports:
- `dac_clk_i`, input, 1: DAC clock.
- `dac_rst_i`, input, 1: reset. Synchronous, active-high.
- `start_i`, input, 1: single-cycle sweep start / retrigger.
- `abort_i`, input, 1: single-cycle abort.
- `cfg_start_i`, input, SW: first step value.
- `cfg_stop_i`, input, SW: final step value.
- `cfg_inc_i`, input, SW: unsigned increment per update.
- `cfg_dwell_i`, input, 32: dwell time in clock cycles per step value. A value of 0 is treated as 1.
- `cfg_repeat_i`, input, 1: 1 = repeat indefinitely, 0 = single sweep.
- `cfg_pp_i`, input, 1: ping-pong mode (only when `ASG_SWEEP_PINGPONG_EN` is defined).
- `step_o`, output, SW: step word to the channel. Registered.
- `upd_o`, output, 1: one-cycle pulse when `step_o` changes.
- `busy_o`, output, 1: high in RUN.
- `wrap_o`, output, 1: one-cycle pulse at each end-of-sweep in repeat mode.
- `done_o`, output, 1: one-cycle pulse when a single sweep completes.

## Operation
- States:
  - IDLE.
  - RUN.
  - DONE.
- Reset state:
  - State is IDLE.
  - `step_o`, `upd_o`, `busy_o`, `wrap_o` and `done_o` are all 0.
  - Latched configuration and the dwell counter are 0.
- `start_i` in any state:
  - Latch all `cfg_*` inputs.
  - Direction is up when `cfg_stop_i` ≥ `cfg_start_i`, otherwise down.
  - `step_o` takes the latched start value; `upd_o` pulses.
  - Dwell counter loads dwell−1; state goes to RUN.
- Configuration changes in RUN take no effect until the next `start_i`.
- In RUN, the dwell counter decrements each cycle. The cycle in which it reads 0 is a tick.
- Tick with `step_o` ≠ stop:
  - Next value is `step_o` ± inc, computed SW+1 bits wide.
  - If the result passes stop or overflows/underflows, it is clamped to stop.
  - `step_o` updates, `upd_o` pulses, and the counter reloads.
- Tick with `step_o` = stop (end-of-sweep):
  - Single sweep: go to DONE, pulse `done_o`, hold `step_o` = stop.
  - Repeat: reload `step_o` with start, pulse `wrap_o` and `upd_o`, stay in RUN.
- DONE behaves like IDLE apart from the held output. `start_i` leaves it.
- `abort_i` in any state:
  - Go to IDLE and set `step_o` to the latched start value.
  - Pulse `upd_o` only if the value changed.
  - No `done_o` or `wrap_o` pulse.
- Priority: `dac_rst_i` > `abort_i` > `start_i` > tick.
- Degenerate configurations:
  - start = stop: every tick is an end-of-sweep.
  - inc = 0 with start ≠ stop: the step never advances, and this is legal.

## Timing
- `start_i` in cycle t:
  - `step_o` = start and `busy_o` = 1 in t+1.
  - First increment appears in t+1+dwell.
- Every step value, including stop, is held exactly `dwell` cycles.
- In a single sweep, `done_o` asserts in the cycle after the stop value's dwell ends. `busy_o` falls in that same cycle.
- `upd_o`, `wrap_o` and `done_o` are asserted in the same cycle as the `step_o` change they describe.
- Abort or reset mid-sweep takes effect in the next cycle.

## Configuration
- `ASG_SWEEP_PINGPONG_EN` defined:
  - With `cfg_pp_i` = 1 and `cfg_repeat_i` = 1, each end-of-sweep swaps the latched start and stop and inverts direction.
  - `step_o` keeps the stop value (no reload) and `wrap_o` pulses.
  - The next tick moves toward the old start.
- Without the macro:
  - The `cfg_pp_i` port is absent.
  - Repeat always reloads start (sawtooth sweep).

## Structure
- Package `asg_sweep_pkg`:
  - State enum (IDLE/RUN/DONE).
  - `SW` width helper.
  - Dwell-zero normalisation constant.
- One sub-module, `asg_sweep_step`: combinational clamped add/subtract. Inputs are current, inc, stop and direction; outputs are next and `at_stop`.
- The FSM, dwell counter and config latches live in the top module.

## Test plan
- Single up sweep, start=100, stop=130, inc=10, dwell=3:
  - `step_o` = 100, 110, 120, 130, each held 3 cycles.
  - `done_o` at cycle t+13; `busy_o` low from t+13.
- Clamp, start=0, stop=25, inc=10, dwell=1:
  - Sequence 0, 10, 20, 25, then DONE.
- Down sweep with repeat, start=50, stop=20, inc=15, dwell=2:
  - Sequence 50, 35, 20, 50, 35, …
  - `wrap_o` at each reload to 50; `done_o` never asserts.
- Abort:
  - `abort_i` mid-sweep at step 120 → IDLE next cycle, `step_o` = start, no `done_o`.
  - `abort_i` and `start_i` in the same cycle → abort wins.
- Retrigger and dwell=0:
  - `start_i` during RUN with new cfg (start=5) → `step_o` = 5 next cycle with the new parameters.
  - dwell=0 advances every cycle.
- Ping-pong (`ASG_SWEEP_PINGPONG_EN`), start=0, stop=20, inc=10, dwell=1, repeat=1, pp=1:
  - Sequence 0, 10, 20, 20, 10, 0, 0, 10, …
  - `wrap_o` on each repeated endpoint cycle.
